// File: rtl/id_stage_scoreboard.sv
// Registered decode stage with a per-register pending-write scoreboard.
// RAW/WAW-saturation hazards back-pressure IF through the in_valid/in_ready handshake.
module id_stage_scoreboard #(
  parameter int INSTR_W   = 16,
  parameter int PC_W      = 16,
  parameter int NUM_REGS  = 8,
  parameter int REG_IDX_W = 3,
  parameter int CNT_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   in_instr,
  input  logic [PC_W-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INSTR_W-1:0]   out_instr,
  output logic [PC_W-1:0]      out_pc,
  output logic [REG_IDX_W-1:0] out_rs,
  output logic [REG_IDX_W-1:0] out_rt,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic                 out_wr_en,
  output logic                 out_is_ld,
  output logic                 out_halt,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_reg,
  input  logic                 flush,
  output logic                 stall_haz,
  output logic                 sb_busy,
  output logic                 halted
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [4:0]           opcode;
  logic [REG_IDX_W-1:0] rs_f, rt_f, rdr_f;
  logic                 uses_rs, uses_rt, dec_wr, dec_ld, dec_halt;
  logic [REG_IDX_W-1:0] dec_rd;
  logic                 haz, accept;
  logic [CNT_W-1:0]     cnt      [NUM_REGS];
  logic [CNT_W-1:0]     cnt_next [NUM_REGS];

  // Counter step: +1 on issue, -1 per retire/squash, never below zero.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dwb,
                                                input logic dfl);
    logic [CNT_W:0] sum_v;
    logic [CNT_W:0] sub_v;
    sum_v = {1'b0, c} + {{CNT_W{1'b0}}, inc};
    sub_v = {{CNT_W{1'b0}}, dwb} + {{CNT_W{1'b0}}, dfl};
    return (sum_v >= sub_v) ? CNT_W'(sum_v - sub_v) : {CNT_W{1'b0}};
  endfunction

  assign opcode = in_instr[INSTR_W-1 -: 5];
  assign rs_f   = in_instr[10:8];
  assign rt_f   = in_instr[7:5];
  assign rdr_f  = in_instr[4:2];

  // Decode register usage of the instruction offered by IF; first match wins.
  always_comb begin
    uses_rs  = 1'b0;
    uses_rt  = 1'b0;
    dec_wr   = 1'b0;
    dec_ld   = 1'b0;
    dec_halt = 1'b0;
    dec_rd   = {REG_IDX_W{1'b0}};
    casez (opcode)
      5'b00000: dec_halt = 1'b1;
      5'b00001: dec_halt = 1'b0;
      5'b00110: begin dec_wr = 1'b1; dec_rd = REG_IDX_W'(7); end
      5'b00111: begin uses_rs = 1'b1; dec_wr = 1'b1; dec_rd = REG_IDX_W'(7); end
      5'b001??: uses_rs = 1'b1;
      5'b01???: begin uses_rs = 1'b1; dec_wr = 1'b1; dec_rd = rt_f; end
      5'b10000: begin uses_rs = 1'b1; uses_rt = 1'b1; end
      5'b10001: begin uses_rs = 1'b1; dec_wr = 1'b1; dec_rd = rt_f; dec_ld = 1'b1; end
      5'b10011: begin uses_rs = 1'b1; uses_rt = 1'b1; dec_wr = 1'b1; dec_rd = rs_f; end
      5'b11???: begin uses_rs = 1'b1; uses_rt = 1'b1; dec_wr = 1'b1; dec_rd = rdr_f; end
      default:  dec_halt = 1'b0;
    endcase
  end

  // Hazards use pre-edge counters, so a same-cycle retirement does not release the stall.
  assign haz = (uses_rs && (cnt[rs_f] != {CNT_W{1'b0}})) ||
               (uses_rt && (cnt[rt_f] != {CNT_W{1'b0}})) ||
               (dec_wr  && (cnt[dec_rd] == CNT_MAX));

  assign in_ready  = ~rst & ~halted & ~flush & ~haz & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign stall_haz = ~rst & in_valid & haz & ~halted;

  // Next-state for every scoreboard counter plus the busy summary.
  always_comb begin
    sb_busy = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_next[r] = cnt_step(cnt[r],
                             accept & dec_wr & (dec_rd == REG_IDX_W'(r)),
                             wb_valid & (wb_reg == REG_IDX_W'(r)) & (cnt[r] != {CNT_W{1'b0}}),
                             flush & out_valid & out_wr_en & ~out_ready & (out_rd == REG_IDX_W'(r)));
      sb_busy = sb_busy | (cnt[r] != {CNT_W{1'b0}});
    end
  end

  // Scoreboard counter registers.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rst) begin
        cnt[r] <= {CNT_W{1'b0}};
      end else begin
        cnt[r] <= cnt_next[r];
      end
    end
  end

  // Output register and halt latch; data only changes on accept so it holds under back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= {INSTR_W{1'b0}};
      out_pc    <= {PC_W{1'b0}};
      out_rs    <= {REG_IDX_W{1'b0}};
      out_rt    <= {REG_IDX_W{1'b0}};
      out_rd    <= {REG_IDX_W{1'b0}};
      out_wr_en <= 1'b0;
      out_is_ld <= 1'b0;
      out_halt  <= 1'b0;
      halted    <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_instr <= in_instr;
        out_pc    <= in_pc;
        out_rs    <= rs_f;
        out_rt    <= rt_f;
        out_rd    <= dec_rd;
        out_wr_en <= dec_wr;
        out_is_ld <= dec_ld;
        out_halt  <= dec_halt;
      end else if (out_ready || flush) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
      if (accept && dec_halt) begin
        halted <= 1'b1;
      end else begin
        halted <= halted;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_scoreboard.sv
// Self-checking bench for id_stage_scoreboard: directed scenarios plus a randomized run
// checked against a behavioural model of the decode table and per-register pending counts.
module tb_id_stage_scoreboard;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic        out_wr_en, out_is_ld, out_halt, wb_valid, flush, stall_haz, sb_busy, halted;
  logic [15:0] in_instr, in_pc, out_instr, out_pc;
  logic [2:0]  out_rs, out_rt, out_rd, wb_reg;

  int checks = 0;
  int failures = 0;

  // model state
  int          m_cnt [8];
  bit          m_ov, m_halted;
  logic [15:0] m_instr, m_pc;

  always #5 clk = ~clk;

  id_stage_scoreboard dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_rs(out_rs), .out_rt(out_rt),
    .out_rd(out_rd), .out_wr_en(out_wr_en), .out_is_ld(out_is_ld), .out_halt(out_halt),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush), .stall_haz(stall_haz),
    .sb_busy(sb_busy), .halted(halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input logic [15:0] ins, input logic [15:0] pc,
                       input bit ordy, input bit wbv, input logic [2:0] wbr, input bit fl);
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    wb_valid  = wbv;
    wb_reg    = wbr;
    flush     = fl;
  endtask

  // Reference decode straight from the opcode table.
  function automatic void mdec(input logic [15:0] ins, output bit urs, output bit urt,
                               output bit wr, output bit ld, output bit hlt, output int rd);
    int op;
    op = int'(ins[15:11]);
    urs = 0; urt = 0; wr = 0; ld = 0; hlt = 0; rd = 0;
    if (op == 0) hlt = 1;
    else if (op == 6) begin wr = 1; rd = 7; end
    else if (op == 7) begin urs = 1; wr = 1; rd = 7; end
    else if (op == 4 || op == 5) urs = 1;
    else if (op >= 8 && op <= 15) begin urs = 1; wr = 1; rd = int'(ins[7:5]); end
    else if (op == 16) begin urs = 1; urt = 1; end
    else if (op == 17) begin urs = 1; wr = 1; rd = int'(ins[7:5]); ld = 1; end
    else if (op == 19) begin urs = 1; urt = 1; wr = 1; rd = int'(ins[10:8]); end
    else if (op >= 24) begin urs = 1; urt = 1; wr = 1; rd = int'(ins[4:2]); end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 16'h0000, 16'h0000, 1, 0, 3'd0, 0);
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0b exp=0", halted); end
    checks++; if (sb_busy !== 1'b0) begin failures++; $display("FAIL reset_sb_busy got=%0b exp=0", sb_busy); end
    checks++; if (stall_haz !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall_haz); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_during got=%0b exp=0", in_ready); end
    checks++; if (out_instr !== 16'h0000 || out_pc !== 16'h0000) begin
      failures++; $display("FAIL reset_out_data got=%h/%h exp=0000/0000", out_instr, out_pc); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_after got=%0b exp=1", in_ready); end
  endtask

  task automatic test_raw_stall();
    drive(1, 16'h4360, 16'h0002, 1, 0, 3'd0, 0);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL raw_first_ready got=%0b exp=1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_instr !== 16'h4360 || out_pc !== 16'h0002) begin
      failures++; $display("FAIL raw_first_issue got=%0b/%h/%h exp=1/4360/0002", out_valid, out_instr, out_pc); end
    checks++; if (out_wr_en !== 1'b1 || out_rd !== 3'd3 || out_rs !== 3'd3) begin
      failures++; $display("FAIL raw_first_decode got=%0b/%0d/%0d exp=1/3/3", out_wr_en, out_rd, out_rs); end
    checks++; if (sb_busy !== 1'b1) begin failures++; $display("FAIL raw_busy got=%0b exp=1", sb_busy); end
    drive(1, 16'hC330, 16'h0004, 1, 0, 3'd0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall_haz !== 1'b1 || in_ready !== 1'b0) begin
        failures++; $display("FAIL raw_stall cyc=%0d got=%0b/%0b exp=1/0", i, stall_haz, in_ready); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL raw_drained got=%0b exp=0", out_valid); end
    drive(1, 16'hC330, 16'h0004, 1, 1, 3'd3, 0);
    #1;
    checks++; if (stall_haz !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL raw_same_cycle_wb got=%0b/%0b exp=1/0", stall_haz, in_ready); end
    tick();
    drive(1, 16'hC330, 16'h0004, 1, 0, 3'd0, 0);
    #1;
    checks++; if (stall_haz !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL raw_release got=%0b/%0b exp=0/1", stall_haz, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_instr !== 16'hC330 || out_rd !== 3'd4 || out_rt !== 3'd1) begin
      failures++; $display("FAIL raw_second_issue got=%0b/%h/%0d/%0d exp=1/c330/4/1", out_valid, out_instr, out_rd, out_rt); end
    drive(0, 16'h0000, 16'h0000, 1, 1, 3'd4, 0);
    tick();
    drive(0, 16'h0000, 16'h0000, 1, 0, 3'd0, 0);
    #1;
    checks++; if (sb_busy !== 1'b0) begin failures++; $display("FAIL raw_all_retired got=%0b exp=0", sb_busy); end
  endtask

  task automatic test_same_cycle_inc_dec();
    drive(1, 16'h8840, 16'h0010, 1, 0, 3'd0, 0);
    tick();
    checks++; if (out_is_ld !== 1'b1 || out_rd !== 3'd2) begin
      failures++; $display("FAIL ld_decode got=%0b/%0d exp=1/2", out_is_ld, out_rd); end
    drive(1, 16'h8840, 16'h0012, 1, 1, 3'd2, 0);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL incdec_ready got=%0b exp=1", in_ready); end
    tick();
    drive(1, 16'hC200, 16'h0014, 1, 0, 3'd0, 0);
    #1;
    checks++; if (stall_haz !== 1'b1 || sb_busy !== 1'b1) begin
      failures++; $display("FAIL incdec_still_pending got=%0b/%0b exp=1/1", stall_haz, sb_busy); end
    drive(0, 16'h0000, 16'h0000, 1, 1, 3'd2, 0);
    tick();
    drive(0, 16'h0000, 16'h0000, 1, 0, 3'd0, 0);
    #1;
    checks++; if (sb_busy !== 1'b0) begin failures++; $display("FAIL incdec_count_one got=%0b exp=0", sb_busy); end
  endtask

  task automatic test_backpressure();
    drive(1, 16'h8140, 16'h0010, 1, 0, 3'd0, 0);
    tick();
    drive(1, 16'h8260, 16'h0020, 0, 0, 3'd0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready cyc=%0d got=%0b exp=0", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_instr !== 16'h8140 || out_pc !== 16'h0010) begin
        failures++; $display("FAIL bp_hold cyc=%0d got=%0b/%h/%h exp=1/8140/0010", i, out_valid, out_instr, out_pc); end
    end
    drive(1, 16'h8260, 16'h0020, 1, 0, 3'd0, 0);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%0b exp=1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_instr !== 16'h8260 || out_pc !== 16'h0020) begin
      failures++; $display("FAIL bp_next got=%0b/%h/%h exp=1/8260/0020", out_valid, out_instr, out_pc); end
    drive(0, 16'h0000, 16'h0000, 1, 0, 3'd0, 0);
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    drive(1, 16'h40A0, 16'h0030, 1, 0, 3'd0, 0);
    tick();
    drive(1, 16'h40A0, 16'h0032, 1, 0, 3'd0, 0);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_second_ready got=%0b exp=1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0032 || out_rd !== 3'd5) begin
      failures++; $display("FAIL flush_held got=%0b/%h/%0d exp=1/0032/5", out_valid, out_pc, out_rd); end
    drive(0, 16'h0000, 16'h0000, 0, 0, 3'd0, 1);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || sb_busy !== 1'b1) begin
      failures++; $display("FAIL flush_squash got=%0b/%0b exp=0/1", out_valid, sb_busy); end
    drive(1, 16'h8500, 16'h0034, 1, 0, 3'd0, 0);
    #1;
    checks++; if (stall_haz !== 1'b1) begin failures++; $display("FAIL flush_r5_pending got=%0b exp=1", stall_haz); end
    drive(0, 16'h0000, 16'h0000, 1, 1, 3'd5, 0);
    tick();
    drive(0, 16'h0000, 16'h0000, 1, 0, 3'd0, 0);
    #1;
    checks++; if (sb_busy !== 1'b0) begin failures++; $display("FAIL flush_restored got=%0b exp=0", sb_busy); end
  endtask

  task automatic test_halt();
    drive(1, 16'h0000, 16'h0040, 1, 0, 3'd0, 0);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL halt_accept got=%0b exp=1", in_ready); end
    tick();
    checks++; if (halted !== 1'b1 || out_valid !== 1'b1 || out_halt !== 1'b1) begin
      failures++; $display("FAIL halt_issue got=%0b/%0b/%0b exp=1/1/1", halted, out_valid, out_halt); end
    drive(1, 16'h0800, 16'h0042, 1, 0, 3'd0, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || stall_haz !== 1'b0) begin
        failures++; $display("FAIL halt_closed cyc=%0d got=%0b/%0b exp=0/0", i, in_ready, stall_haz); end
      tick();
      checks++; if (halted !== 1'b1 || out_valid !== 1'b0) begin
        failures++; $display("FAIL halt_sticky cyc=%0d got=%0b/%0b exp=1/0", i, halted, out_valid); end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (halted !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL halt_reset got=%0b/%0b exp=0/1", halted, in_ready); end
  endtask

  task automatic test_random();
    bit urs, urt, wr, ld, hlt, h_urs, h_urt, h_wr, h_ld, h_hlt;
    int rd, h_rd, nxt;
    bit haz, exp_ready, acc, exp_busy, iv, ordy, wbv, fl;
    logic [4:0]  op;
    logic [15:0] ins, pc;
    logic [2:0]  wbr;
    rst = 1'b1;
    drive(0, 16'h0000, 16'h0000, 1, 0, 3'd0, 0);
    tick();
    rst = 1'b0;
    for (int r = 0; r < 8; r++) m_cnt[r] = 0;
    m_ov = 0; m_halted = 0; m_instr = 16'h0000; m_pc = 16'h0000;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      iv   = ($urandom_range(0, 3) != 0);
      op   = 5'($urandom_range(1, 31));
      ins  = {op, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      pc   = 16'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      wbv  = ($urandom_range(0, 9) < 3);
      wbr  = 3'($urandom_range(0, 4));
      fl   = ($urandom_range(0, 19) == 0);
      drive(iv, ins, pc, ordy, wbv, wbr, fl);
      #1;
      mdec(ins, urs, urt, wr, ld, hlt, rd);
      haz = (urs && m_cnt[ins[10:8]] != 0) || (urt && m_cnt[ins[7:5]] != 0) || (wr && m_cnt[rd] == 3);
      exp_ready = !m_halted && !fl && !haz && (!m_ov || ordy);
      checks++; if (in_ready !== exp_ready) begin
        failures++; $display("FAIL rnd_in_ready cyc=%0d instr=%h got=%0b exp=%0b", cyc, ins, in_ready, exp_ready); end
      checks++; if (stall_haz !== (iv && haz && !m_halted)) begin
        failures++; $display("FAIL rnd_stall cyc=%0d instr=%h got=%0b exp=%0b", cyc, ins, stall_haz, iv && haz && !m_halted); end
      acc = iv && exp_ready;
      mdec(m_instr, h_urs, h_urt, h_wr, h_ld, h_hlt, h_rd);
      for (int r = 0; r < 8; r++) begin
        nxt = m_cnt[r];
        if (acc && wr && rd == r) nxt++;
        if (wbv && int'(wbr) == r && m_cnt[r] > 0) nxt--;
        if (fl && m_ov && h_wr && !ordy && h_rd == r) nxt--;
        m_cnt[r] = (nxt < 0) ? 0 : nxt;
      end
      if (acc) begin
        m_ov = 1; m_instr = ins; m_pc = pc;
        if (hlt) m_halted = 1;
      end else if (ordy || fl) begin
        m_ov = 0;
      end
      tick();
      exp_busy = 0;
      for (int r = 0; r < 8; r++) if (m_cnt[r] != 0) exp_busy = 1;
      mdec(m_instr, h_urs, h_urt, h_wr, h_ld, h_hlt, h_rd);
      checks++; if (out_valid !== m_ov || sb_busy !== exp_busy || halted !== m_halted) begin
        failures++; $display("FAIL rnd_status cyc=%0d got=%0b/%0b/%0b exp=%0b/%0b/%0b",
                             cyc, out_valid, sb_busy, halted, m_ov, exp_busy, m_halted); end
      if (m_ov) begin
        checks++; if (out_instr !== m_instr || out_pc !== m_pc || out_rs !== m_instr[10:8] || out_rt !== m_instr[7:5]) begin
          failures++; $display("FAIL rnd_data cyc=%0d got=%h/%h/%0d/%0d exp=%h/%h/%0d/%0d", cyc,
                               out_instr, out_pc, out_rs, out_rt, m_instr, m_pc, m_instr[10:8], m_instr[7:5]); end
        checks++; if (out_wr_en !== h_wr || out_is_ld !== h_ld || out_halt !== h_hlt || (h_wr && int'(out_rd) != h_rd)) begin
          failures++; $display("FAIL rnd_decode cyc=%0d instr=%h got=%0b/%0b/%0b/%0d exp=%0b/%0b/%0b/%0d", cyc, m_instr,
                               out_wr_en, out_is_ld, out_halt, out_rd, h_wr, h_ld, h_hlt, h_rd); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 16'h0000, 16'h0000, 1, 0, 3'd0, 0);
    test_reset();
    test_raw_stall();
    test_same_cycle_inc_dec();
    test_backpressure();
    test_flush();
    test_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
